// File: rtl/npc_core_sequencer.sv
// npc_core_sequencer: multi-cycle fetch/execute sequencer for the NPC core.
// Owns the PC, issues one fetch per retired instruction, hands the opcode to the
// EXU and retires on EXU completion toggles. Handles ebreak, fetch bus errors,
// misaligned next_pc and a transaction watchdog. All outputs are registered.
module npc_core_sequencer #(
   parameter logic [31:0] RESET_PC       = 32'h2000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             halt_req,
   output logic             ifu_req,
   output logic [31:0]      ifu_addr,
   input  logic             ifu_rvalid,
   input  logic [31:0]      ifu_rdata,
   input  logic [1:0]       ifu_rresp,
   output logic             op_en,
   output logic [31:0]      op,
   input  logic             ex_done,
   input  logic [31:0]      next_pc,
   input  logic             ebreak,
   input  logic [31:0]      exit_code,
   output logic [31:0]      pc,
   output logic             trap_valid,
   output logic [31:0]      trap_code,
   output logic             halted,
   output logic             fault,
   output logic [1:0]       fault_cause,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [2:0] {
      S_BOOT,
      S_FETCH_REQ,
      S_FETCH_WAIT,
      S_EXEC,
      S_HALT,
      S_FAULT
   } state_t;

   localparam logic [1:0]  CAUSE_BUS   = 2'd1;
   localparam logic [1:0]  CAUSE_WDOG  = 2'd2;
   localparam logic [1:0]  CAUSE_ALIGN = 2'd3;
   localparam bit          WD_EN       = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] WD_LAST     = WD_EN ? 32'(TIMEOUT_CYCLES - 1) : '0;

   state_t             r_state;
   logic [31:0]        r_pc;
   logic [31:0]        r_ifu_addr;
   logic               r_ifu_req;
   logic               r_op_en;
   logic [31:0]        r_op;
   logic               r_trap_valid;
   logic [31:0]        r_trap_code;
   logic               r_halted;
   logic               r_fault;
   logic [1:0]         r_fault_cause;
   logic [CNT_W-1:0]   r_instret;
   logic [31:0]        r_wdog;
   logic               r_ex_done_prev;

   state_t             w_state_nxt;
   logic [31:0]        w_pc_nxt;
   logic [31:0]        w_ifu_addr_nxt;
   logic               w_ifu_req_nxt;
   logic               w_op_en_nxt;
   logic [31:0]        w_op_nxt;
   logic               w_trap_valid_nxt;
   logic [31:0]        w_trap_code_nxt;
   logic               w_halted_nxt;
   logic               w_fault_nxt;
   logic [1:0]         w_fault_cause_nxt;
   logic [CNT_W-1:0]   w_instret_nxt;
   logic [31:0]        w_wdog_nxt;
   logic               w_completion;
   logic               w_wd_expired;

   assign w_completion = ex_done ^ r_ex_done_prev;
   assign w_wd_expired = WD_EN && (r_wdog == WD_LAST);

   // Completion edge detector: tracks ex_done every cycle in every state.
   // Kept out of the async reset so the reset value needs no data-dependent load;
   // it simply re-samples ex_done on the first clock after (or during) reset.
   always_ff @(posedge clk) begin
      r_ex_done_prev <= ex_done;
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_BOOT;
         r_pc          <= RESET_PC;
         r_ifu_addr    <= RESET_PC;
         r_ifu_req     <= 1'b0;
         r_op_en       <= 1'b0;
         r_op          <= '0;
         r_trap_valid  <= 1'b0;
         r_trap_code   <= '0;
         r_halted      <= 1'b0;
         r_fault       <= 1'b0;
         r_fault_cause <= '0;
         r_instret     <= '0;
         r_wdog        <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_ifu_addr    <= w_ifu_addr_nxt;
         r_ifu_req     <= w_ifu_req_nxt;
         r_op_en       <= w_op_en_nxt;
         r_op          <= w_op_nxt;
         r_trap_valid  <= w_trap_valid_nxt;
         r_trap_code   <= w_trap_code_nxt;
         r_halted      <= w_halted_nxt;
         r_fault       <= w_fault_nxt;
         r_fault_cause <= w_fault_cause_nxt;
         r_instret     <= w_instret_nxt;
         r_wdog        <= w_wdog_nxt;
      end
   end

   // Next-state and next-output decode; responses take priority over the watchdog.
   always_comb begin
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_ifu_addr_nxt    = r_ifu_addr;
      w_ifu_req_nxt     = 1'b0;
      w_op_en_nxt       = 1'b0;
      w_op_nxt          = r_op;
      w_trap_valid_nxt  = 1'b0;
      w_trap_code_nxt   = r_trap_code;
      w_halted_nxt      = r_halted;
      w_fault_nxt       = r_fault;
      w_fault_cause_nxt = r_fault_cause;
      w_instret_nxt     = r_instret;
      w_wdog_nxt        = r_wdog;
      case (r_state)
         S_BOOT: begin
            w_state_nxt = S_FETCH_REQ;
         end
         S_FETCH_REQ: begin
            if (!halt_req) begin
               w_ifu_req_nxt  = 1'b1;
               w_ifu_addr_nxt = r_pc;
               w_wdog_nxt     = '0;
               w_state_nxt    = S_FETCH_WAIT;
            end
         end
         S_FETCH_WAIT: begin
            if (ifu_rvalid) begin
               if (ifu_rresp != 2'b00) begin
                  w_fault_nxt       = 1'b1;
                  w_fault_cause_nxt = CAUSE_BUS;
                  w_state_nxt       = S_FAULT;
               end else begin
                  w_op_nxt    = ifu_rdata;
                  w_op_en_nxt = 1'b1;
                  w_wdog_nxt  = '0;
                  w_state_nxt = S_EXEC;
               end
            end else if (w_wd_expired) begin
               w_fault_nxt       = 1'b1;
               w_fault_cause_nxt = CAUSE_WDOG;
               w_state_nxt       = S_FAULT;
            end else begin
               w_wdog_nxt = r_wdog + 32'd1;
            end
         end
         S_EXEC: begin
            if (w_completion) begin
               if (ebreak) begin
                  w_instret_nxt    = r_instret + CNT_W'(1);
                  w_trap_code_nxt  = exit_code;
                  w_trap_valid_nxt = 1'b1;
                  w_halted_nxt     = 1'b1;
                  w_state_nxt      = S_HALT;
               end else if (next_pc[1:0] != 2'b00) begin
                  w_fault_nxt       = 1'b1;
                  w_fault_cause_nxt = CAUSE_ALIGN;
                  w_state_nxt       = S_FAULT;
               end else begin
                  w_instret_nxt = r_instret + CNT_W'(1);
                  w_pc_nxt      = next_pc;
                  w_state_nxt   = S_FETCH_REQ;
               end
            end else if (w_wd_expired) begin
               w_fault_nxt       = 1'b1;
               w_fault_cause_nxt = CAUSE_WDOG;
               w_state_nxt       = S_FAULT;
            end else begin
               w_wdog_nxt = r_wdog + 32'd1;
            end
         end
         S_HALT, S_FAULT: begin
            w_state_nxt = r_state;
         end
         default: begin
            w_state_nxt = S_BOOT;
         end
      endcase
   end

   assign ifu_req     = r_ifu_req;
   assign ifu_addr    = r_ifu_addr;
   assign op_en       = r_op_en;
   assign op          = r_op;
   assign pc          = r_pc;
   assign trap_valid  = r_trap_valid;
   assign trap_code   = r_trap_code;
   assign halted      = r_halted;
   assign fault       = r_fault;
   assign fault_cause = r_fault_cause;
   assign instret     = r_instret;

endmodule

// File: tb/tb_npc_core_sequencer.sv
// Self-checking bench for npc_core_sequencer: the bench plays IFU and EXU with
// random latencies and data, and predicts PC, instret, opcodes and the exact
// cycle of each request, trap and fault from the sequencer's documented rules.
module tb_npc_core_sequencer;

   localparam logic [31:0] RST_PC = 32'h2000_0000;
   localparam int unsigned WD     = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        halt_req = 1'b0;
   logic        ifu_req;
   logic [31:0] ifu_addr;
   logic        ifu_rvalid = 1'b0;
   logic [31:0] ifu_rdata = '0;
   logic [1:0]  ifu_rresp = '0;
   logic        op_en;
   logic [31:0] op;
   logic        ex_done = 1'b0;
   logic [31:0] next_pc = '0;
   logic        ebreak = 1'b0;
   logic [31:0] exit_code = '0;
   logic [31:0] pc;
   logic        trap_valid;
   logic [31:0] trap_code;
   logic        halted;
   logic        fault;
   logic [1:0]  fault_cause;
   logic [31:0] instret;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_pc;
   logic [31:0] exp_instret;
   logic [31:0] last_op;

   npc_core_sequencer #(
      .RESET_PC       (RST_PC),
      .TIMEOUT_CYCLES (WD),
      .CNT_W          (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .halt_req    (halt_req),
      .ifu_req     (ifu_req),
      .ifu_addr    (ifu_addr),
      .ifu_rvalid  (ifu_rvalid),
      .ifu_rdata   (ifu_rdata),
      .ifu_rresp   (ifu_rresp),
      .op_en       (op_en),
      .op          (op),
      .ex_done     (ex_done),
      .next_pc     (next_pc),
      .ebreak      (ebreak),
      .exit_code   (exit_code),
      .pc          (pc),
      .trap_valid  (trap_valid),
      .trap_code   (trap_code),
      .halted      (halted),
      .fault       (fault),
      .fault_cause (fault_cause),
      .instret     (instret)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   // Reset, release, and expect the first request exactly two cycles later.
   task automatic boot();
      rst = 1'b1; halt_req = 1'b0; ifu_rvalid = 1'b0; ifu_rresp = '0; ebreak = 1'b0;
      tick(); tick();
      rst = 1'b0;
      exp_pc = RST_PC; exp_instret = '0; last_op = '0;
      tick(); tick();
      n_checks++;
      if (ifu_req !== 1'b1 || ifu_addr !== RST_PC) begin
         n_fail++;
         $display("FAIL boot_req: ifu_req=%b ifu_addr=%h, want 1 %h", ifu_req, ifu_addr, RST_PC);
      end
   endtask

   // Starts with ifu_req visible; answers after flat cycles; ends with op_en visible.
   task automatic do_fetch(input logic [31:0] rdata, input int flat);
      for (int i = 0; i < flat; i++) begin
         halt_req = 1'($urandom_range(0, 1));
         tick();
         n_checks++;
         if (ifu_req !== 1'b0 || op_en !== 1'b0 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_wait_quiet: ifu_req=%b op_en=%b fault=%b, want 0 0 0", ifu_req, op_en, fault);
         end
      end
      halt_req = 1'b0; ifu_rvalid = 1'b1; ifu_rdata = rdata; ifu_rresp = 2'b00;
      tick();
      ifu_rvalid = 1'b0; ifu_rdata = $urandom;
      last_op = rdata;
      n_checks++;
      if (op_en !== 1'b1 || op !== rdata || fault !== 1'b0) begin
         n_fail++;
         $display("FAIL fetch_op: op_en=%b op=%h fault=%b, want 1 %h 0", op_en, op, fault, rdata);
      end
   endtask

   // Waits elat cycles in EXEC, optionally with a stray fetch response.
   task automatic do_exec_wait(input int elat, input bit stray);
      for (int i = 0; i < elat; i++) begin
         ifu_rvalid = stray && (i == 0);
         ifu_rdata  = $urandom;
         ifu_rresp  = 2'($urandom_range(0, 3));
         halt_req   = 1'($urandom_range(0, 1));
         tick();
         n_checks++;
         if (op_en !== 1'b0 || op !== last_op || ifu_req !== 1'b0 || fault !== 1'b0 ||
             pc !== exp_pc || instret !== exp_instret) begin
            n_fail++;
            $display("FAIL exec_wait: op_en=%b op=%h ifu_req=%b fault=%b pc=%h instret=%0d, want 0 %h 0 0 %h %0d",
                     op_en, op, ifu_req, fault, pc, instret, last_op, exp_pc, exp_instret);
         end
      end
      ifu_rvalid = 1'b0; ifu_rresp = 2'b00; halt_req = 1'b0;
   endtask

   // Normal retirement, then hold halt_req for hold cycles in FETCH_REQ.
   task automatic do_retire(input logic [31:0] npc, input int hold);
      ex_done = ~ex_done; next_pc = npc; ebreak = 1'b0; exit_code = $urandom;
      tick();
      exp_pc = npc; exp_instret = exp_instret + 32'd1;
      n_checks++;
      if (pc !== exp_pc || instret !== exp_instret || ifu_req !== 1'b0 || fault !== 1'b0 || halted !== 1'b0) begin
         n_fail++;
         $display("FAIL retire: pc=%h instret=%0d ifu_req=%b fault=%b halted=%b, want %h %0d 0 0 0",
                  pc, instret, ifu_req, fault, halted, exp_pc, exp_instret);
      end
      halt_req = (hold > 0);
      for (int i = 0; i < hold; i++) begin
         tick();
         n_checks++;
         if (ifu_req !== 1'b0 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_hold: ifu_req=%b fault=%b at hold cycle %0d, want 0 0", ifu_req, fault, i);
         end
      end
      halt_req = 1'b0;
      tick();
      n_checks++;
      if (ifu_req !== 1'b1 || ifu_addr !== exp_pc) begin
         n_fail++;
         $display("FAIL refetch: ifu_req=%b ifu_addr=%h, want 1 %h", ifu_req, ifu_addr, exp_pc);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      n_checks++;
      if (pc !== RST_PC || ifu_addr !== RST_PC) begin
         n_fail++;
         $display("FAIL reset_pc: pc=%h ifu_addr=%h, want %h", pc, ifu_addr, RST_PC);
      end
      n_checks++;
      if ({ifu_req, op_en, trap_valid, halted, fault} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: %b, want 00000", {ifu_req, op_en, trap_valid, halted, fault});
      end
      n_checks++;
      if (op !== '0 || trap_code !== '0 || fault_cause !== 2'd0 || instret !== '0) begin
         n_fail++;
         $display("FAIL reset_data: op=%h trap_code=%h cause=%0d instret=%0d, want 0", op, trap_code, fault_cause, instret);
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (ifu_req !== 1'b0) begin
         n_fail++;
         $display("FAIL boot_cycle1: ifu_req=%b, want 0", ifu_req);
      end
      tick();
      n_checks++;
      if (ifu_req !== 1'b1 || ifu_addr !== RST_PC) begin
         n_fail++;
         $display("FAIL boot_cycle2: ifu_req=%b ifu_addr=%h, want 1 %h", ifu_req, ifu_addr, RST_PC);
      end
      tick();
      n_checks++;
      if (ifu_req !== 1'b0) begin
         n_fail++;
         $display("FAIL req_pulse: ifu_req=%b, want 0", ifu_req);
      end
   endtask

   task automatic test_step();
      boot();
      do_fetch(32'h0010_0093, 1);
      do_exec_wait(2, 1'b0);
      do_retire(32'h2000_0004, 0);
   endtask

   task automatic test_random_stream();
      boot();
      for (int n = 0; n < 40; n++) begin
         do_fetch($urandom, $urandom_range(0, 5));
         do_exec_wait($urandom_range(0, 5), ($urandom_range(0, 3) == 0));
         do_retire($urandom & 32'hFFFF_FFFC, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
      end
   endtask

   task automatic test_ebreak(input logic [31:0] code);
      int n_req;
      int n_open;
      int n_trap;
      boot();
      do_fetch($urandom, 0);
      do_exec_wait(1, 1'b0);
      do_retire($urandom & 32'hFFFF_FFFC, 0);
      do_fetch(32'h0010_0073, 2);
      do_exec_wait(1, 1'b0);
      // misaligned next_pc alongside ebreak: ebreak must win
      ex_done = ~ex_done; ebreak = 1'b1; exit_code = code; next_pc = exp_pc | 32'd2;
      tick();
      ebreak = 1'b0;
      exp_instret = exp_instret + 32'd1;
      n_checks++;
      if (trap_valid !== 1'b1 || trap_code !== code || halted !== 1'b1 || fault !== 1'b0 ||
          instret !== exp_instret || pc !== exp_pc) begin
         n_fail++;
         $display("FAIL ebreak_retire: tv=%b code=%h halted=%b fault=%b instret=%0d pc=%h, want 1 %h 1 0 %0d %h",
                  trap_valid, trap_code, halted, fault, instret, pc, code, exp_instret, exp_pc);
      end
      tick();
      n_checks++;
      if (trap_valid !== 1'b0 || halted !== 1'b1) begin
         n_fail++;
         $display("FAIL trap_pulse: tv=%b halted=%b, want 0 1", trap_valid, halted);
      end
      n_req = 0; n_open = 0; n_trap = 0;
      for (int i = 0; i < 100; i++) begin
         ex_done = 1'($urandom_range(0, 1)); ebreak = 1'($urandom_range(0, 1));
         ifu_rvalid = 1'($urandom_range(0, 1)); halt_req = 1'($urandom_range(0, 1));
         next_pc = $urandom; exit_code = $urandom;
         tick();
         n_req  += int'(ifu_req);
         n_open += int'(op_en);
         n_trap += int'(trap_valid);
      end
      ebreak = 1'b0; ifu_rvalid = 1'b0; halt_req = 1'b0;
      n_checks++;
      if (n_req != 0 || n_open != 0 || n_trap != 0 || halted !== 1'b1 || instret !== exp_instret || trap_code !== code) begin
         n_fail++;
         $display("FAIL halt_absorb: req=%0d op_en=%0d trap=%0d halted=%b instret=%0d code=%h, want 0 0 0 1 %0d %h",
                  n_req, n_open, n_trap, halted, instret, trap_code, exp_instret, code);
      end
   endtask

   task automatic test_fault_bus();
      int n_req;
      boot();
      do_fetch($urandom, 1);
      do_exec_wait(0, 1'b0);
      do_retire($urandom & 32'hFFFF_FFFC, 0);
      tick();
      ifu_rvalid = 1'b1; ifu_rdata = $urandom; ifu_rresp = 2'b10;
      tick();
      ifu_rvalid = 1'b0; ifu_rresp = 2'b00;
      n_checks++;
      if (fault !== 1'b1 || fault_cause !== 2'd1 || op_en !== 1'b0 || op !== last_op || halted !== 1'b0) begin
         n_fail++;
         $display("FAIL bus_fault: fault=%b cause=%0d op_en=%b op=%h halted=%b, want 1 1 0 %h 0",
                  fault, fault_cause, op_en, op, halted, last_op);
      end
      n_req = 0;
      for (int i = 0; i < 50; i++) begin
         ex_done = 1'($urandom_range(0, 1)); ifu_rvalid = 1'($urandom_range(0, 1));
         tick();
         n_req += int'(ifu_req) + int'(op_en);
      end
      ifu_rvalid = 1'b0;
      n_checks++;
      if (n_req != 0 || fault !== 1'b1 || fault_cause !== 2'd1 || pc !== exp_pc || instret !== exp_instret) begin
         n_fail++;
         $display("FAIL fault_absorb: activity=%0d fault=%b cause=%0d pc=%h instret=%0d, want 0 1 1 %h %0d",
                  n_req, fault, fault_cause, pc, instret, exp_pc, exp_instret);
      end
   endtask

   task automatic test_fault_misaligned(input logic [31:0] bad_pc);
      int n_req;
      boot();
      do_fetch($urandom, 0);
      do_exec_wait(1, 1'b0);
      do_retire($urandom & 32'hFFFF_FFFC, 0);
      do_fetch($urandom, 1);
      do_exec_wait(2, 1'b0);
      ex_done = ~ex_done; next_pc = bad_pc; ebreak = 1'b0;
      tick();
      n_checks++;
      if (fault !== 1'b1 || fault_cause !== 2'd3 || pc !== exp_pc || instret !== exp_instret ||
          halted !== 1'b0 || trap_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL misaligned: fault=%b cause=%0d pc=%h instret=%0d halted=%b tv=%b, want 1 3 %h %0d 0 0",
                  fault, fault_cause, pc, instret, halted, trap_valid, exp_pc, exp_instret);
      end
      n_req = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         n_req += int'(ifu_req);
      end
      n_checks++;
      if (n_req != 0 || pc !== exp_pc) begin
         n_fail++;
         $display("FAIL misaligned_hold: ifu_req count=%0d pc=%h, want 0 %h", n_req, pc, exp_pc);
      end
   endtask

   task automatic test_watchdog();
      // FETCH_WAIT timeout lands exactly WD cycles after the request
      boot();
      for (int i = 1; i < int'(WD); i++) begin
         tick();
         n_checks++;
         if (fault !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_fetch_early: fault=%b at cycle %0d, want 0", fault, i);
         end
      end
      tick();
      n_checks++;
      if (fault !== 1'b1 || fault_cause !== 2'd2) begin
         n_fail++;
         $display("FAIL wd_fetch: fault=%b cause=%0d, want 1 2", fault, fault_cause);
      end
      // EXEC timeout
      boot();
      do_fetch($urandom, 3);
      for (int i = 1; i < int'(WD); i++) tick();
      n_checks++;
      if (fault !== 1'b0) begin
         n_fail++;
         $display("FAIL wd_exec_early: fault=%b, want 0", fault);
      end
      tick();
      n_checks++;
      if (fault !== 1'b1 || fault_cause !== 2'd2 || instret !== exp_instret) begin
         n_fail++;
         $display("FAIL wd_exec: fault=%b cause=%0d instret=%0d, want 1 2 %0d", fault, fault_cause, instret, exp_instret);
      end
      // response on the expiring cycle wins, in both waiting states
      boot();
      do_fetch($urandom, int'(WD) - 1);
      do_exec_wait(int'(WD) - 1, 1'b0);
      do_retire($urandom & 32'hFFFF_FFFC, 0);
   endtask

   task automatic test_halt_req();
      rst = 1'b1; halt_req = 1'b1;
      tick();
      rst = 1'b0;
      exp_pc = RST_PC; exp_instret = '0;
      for (int i = 0; i < 25; i++) begin
         tick();
         n_checks++;
         if (ifu_req !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_boot: ifu_req=%b at cycle %0d, want 0", ifu_req, i);
         end
      end
      halt_req = 1'b0;
      tick();
      n_checks++;
      if (ifu_req !== 1'b1 || ifu_addr !== RST_PC || fault !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_release: ifu_req=%b ifu_addr=%h fault=%b, want 1 %h 0", ifu_req, ifu_addr, fault, RST_PC);
      end
      do_fetch($urandom, 2);
      do_exec_wait(1, 1'b0);
      do_retire($urandom & 32'hFFFF_FFFC, 10);
   endtask

   task automatic test_rst_mid();
      boot();
      do_fetch($urandom, 1);
      do_exec_wait(1, 1'b0);
      do_retire($urandom & 32'hFFFF_FFFC, 0);
      tick(); tick();
      rst = 1'b1;
      #1;
      n_checks++;
      if (pc !== RST_PC || ifu_addr !== RST_PC || instret !== '0 || op !== '0 || ifu_req !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_async: pc=%h ifu_addr=%h instret=%0d op=%h ifu_req=%b, want %h %h 0 0 0",
                  pc, ifu_addr, instret, op, ifu_req, RST_PC, RST_PC);
      end
      tick();
      rst = 1'b0;
      exp_pc = RST_PC; exp_instret = '0; last_op = '0;
      tick();
      ifu_rvalid = 1'b1; ifu_rdata = $urandom; ifu_rresp = 2'b00;
      tick();
      ifu_rvalid = 1'b0;
      n_checks++;
      if (ifu_req !== 1'b1 || ifu_addr !== RST_PC || op_en !== 1'b0 || op !== '0) begin
         n_fail++;
         $display("FAIL late_resp: ifu_req=%b ifu_addr=%h op_en=%b op=%h, want 1 %h 0 0", ifu_req, ifu_addr, op_en, op, RST_PC);
      end
      ex_done = ~ex_done;
      tick();
      n_checks++;
      if (op_en !== 1'b0 || instret !== '0 || pc !== RST_PC) begin
         n_fail++;
         $display("FAIL done_in_wait: op_en=%b instret=%0d pc=%h, want 0 0 %h", op_en, instret, pc, RST_PC);
      end
      do_fetch($urandom, 1);
      do_exec_wait(3, 1'b0);
      do_retire(32'h2000_0010, 0);
   endtask

   initial begin
      test_reset();
      test_step();
      test_random_stream();
      test_ebreak(32'h0000_0000);
      test_ebreak($urandom | 32'h1);
      test_fault_bus();
      test_fault_misaligned(32'h2000_0006);
      test_fault_misaligned(($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3)));
      test_watchdog();
      test_halt_req();
      test_rst_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL sim_timeout: run did not end, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "simulation time limit");
   end

endmodule
